// File: rtl/cpu16_pkg.sv
// Shared widths, opcode encoding and instruction field helpers for the 16-bit teaching CPU.
package cpu16_pkg;

  localparam int IW   = 16;
  localparam int AW   = 9;
  localparam int NREG = 16;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_ADD  = 4'h2,
    OP_SUB  = 4'h3,
    OP_AND  = 4'h4,
    OP_OR   = 4'h5,
    OP_XOR  = 4'h6,
    OP_SHL  = 4'h7,
    OP_SHR  = 4'h8,
    OP_LD   = 4'h9,
    OP_ST   = 4'hA,
    OP_JMP  = 4'hB,
    OP_BEQ  = 4'hC,
    OP_BNE  = 4'hD,
    OP_ADDI = 4'hE,
    OP_HALT = 4'hF
  } opcode_t;

  function automatic opcode_t get_op(input logic [IW-1:0] inst);
    return opcode_t'(inst[15:12]);
  endfunction

  function automatic logic [3:0] get_rd(input logic [IW-1:0] inst);
    return inst[11:8];
  endfunction

  function automatic logic [3:0] get_rs(input logic [IW-1:0] inst);
    return inst[7:4];
  endfunction

  function automatic logic [3:0] get_rb(input logic [IW-1:0] inst);
    return inst[3:0];
  endfunction

  function automatic logic [AW-1:0] get_disp9(input logic [IW-1:0] inst);
    return inst[8:0];
  endfunction

  function automatic logic [IW-1:0] sext_imm8(input logic [IW-1:0] inst);
    return {{(IW-8){inst[7]}}, inst[7:0]};
  endfunction

  // Branch offsets are signed, memory offsets are not; both come from the low nibble.
  function automatic logic [AW-1:0] sext_disp4(input logic [IW-1:0] inst);
    return {{(AW-4){inst[3]}}, inst[3:0]};
  endfunction

  function automatic logic [AW-1:0] zext_disp4(input logic [IW-1:0] inst);
    return {{(AW-4){1'b0}}, inst[3:0]};
  endfunction

endpackage

// File: rtl/cpu16_regfile.sv
// 16x16 register file: two combinational read ports, one write port, async clear.
module cpu16_regfile
  import cpu16_pkg::*;
(
  input  logic          ck,
  input  logic          rst,
  input  logic          we,
  input  logic [3:0]    waddr,
  input  logic [IW-1:0] wdata,
  input  logic [3:0]    raddr_a,
  input  logic [3:0]    raddr_b,
  output logic [IW-1:0] rdata_a,
  output logic [IW-1:0] rdata_b
);

  logic [IW-1:0] regs [NREG];

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  // No write bypass: a read in the same cycle as a write sees the old value.
  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/cpu16_fde.sv
// Single-cycle fetch/decode/execute datapath: instruction RAM, decoder, ALU,
// next-PC logic and the sticky halted flag.
module cpu16_fde
  import cpu16_pkg::*;
(
  input  logic          ck,
  input  logic          rst,
  input  logic [AW-1:0] pc,
  input  logic          imem_we,
  input  logic [AW-1:0] imem_waddr,
  input  logic [IW-1:0] imem_wdata,
  input  logic [IW-1:0] ld_data,
  output logic [AW-1:0] next_pc,
  output logic          is_jump,
  output logic          is_halt,
  output logic          is_load,
  output logic [AW-1:0] load_addr,
  output logic          is_write,
  output logic [AW-1:0] write_addr,
  output logic [IW-1:0] data
);

  logic [IW-1:0] imem [1 << AW];
  logic [IW-1:0] inst;
  opcode_t       op;
  logic          halted;
  logic          halt_now;
  logic [3:0]    raddr_b;
  logic [IW-1:0] ra_data;
  logic [IW-1:0] rb_data;
  logic          reg_we;
  logic [IW-1:0] reg_wdata;
  logic [AW-1:0] mem_addr;
  logic [AW-1:0] branch_target;

  // Program load port; deliberately not reset so a reset keeps the program.
  always_ff @(posedge ck) begin
    if (imem_we) begin
      imem[imem_waddr] <= imem_wdata;
    end
  end

  assign inst     = imem[pc];
  assign op       = get_op(inst);
  assign halt_now = halted || (op == OP_HALT);
  assign raddr_b  = (op inside {OP_ST, OP_BEQ, OP_BNE, OP_ADDI}) ? get_rd(inst) : get_rb(inst);

  cpu16_regfile u_regfile (
    .ck      (ck),
    .rst     (rst),
    .we      (reg_we),
    .waddr   (get_rd(inst)),
    .wdata   (reg_wdata),
    .raddr_a (get_rs(inst)),
    .raddr_b (raddr_b),
    .rdata_a (ra_data),
    .rdata_b (rb_data)
  );

  assign mem_addr      = ra_data[AW-1:0] + zext_disp4(inst);
  assign branch_target = pc + sext_disp4(inst);

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      halted <= 1'b0;
    end else if (op == OP_HALT) begin
      halted <= 1'b1;
    end
  end

  assign is_halt = !rst && halt_now;

  // Reset and halt both squash every side effect; only next_pc differs between them.
  always_comb begin
    next_pc    = pc + AW'(1);
    is_jump    = 1'b0;
    is_load    = 1'b0;
    load_addr  = '0;
    is_write   = 1'b0;
    write_addr = '0;
    data       = '0;
    reg_we     = 1'b0;
    reg_wdata  = '0;
    if (rst) begin
      next_pc = '0;
    end else if (halt_now) begin
      next_pc = pc;
    end else begin
      case (op)
        OP_LDI:  begin reg_we = 1'b1; reg_wdata = sext_imm8(inst); end
        OP_ADD:  begin reg_we = 1'b1; reg_wdata = ra_data + rb_data; end
        OP_SUB:  begin reg_we = 1'b1; reg_wdata = ra_data - rb_data; end
        OP_AND:  begin reg_we = 1'b1; reg_wdata = ra_data & rb_data; end
        OP_OR:   begin reg_we = 1'b1; reg_wdata = ra_data | rb_data; end
        OP_XOR:  begin reg_we = 1'b1; reg_wdata = ra_data ^ rb_data; end
        OP_SHL:  begin reg_we = 1'b1; reg_wdata = ra_data << rb_data[3:0]; end
        OP_SHR:  begin reg_we = 1'b1; reg_wdata = ra_data >> rb_data[3:0]; end
        OP_LD: begin
          reg_we    = 1'b1;
          reg_wdata = ld_data;
          is_load   = 1'b1;
          load_addr = mem_addr;
        end
        OP_ST: begin
          is_write   = 1'b1;
          write_addr = mem_addr;
          data       = rb_data;
        end
        OP_JMP: begin
          next_pc = get_disp9(inst);
          is_jump = 1'b1;
        end
        OP_BEQ: begin
          if (ra_data == rb_data) begin
            next_pc = branch_target;
            is_jump = 1'b1;
          end
        end
        OP_BNE: begin
          if (ra_data != rb_data) begin
            next_pc = branch_target;
            is_jump = 1'b1;
          end
        end
        OP_ADDI: begin reg_we = 1'b1; reg_wdata = rb_data + sext_imm8(inst); end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu16_fde.sv
// Self-checking bench for cpu16_fde: an arithmetic reference model checked on every
// falling edge, plus directed literal expectations for each scenario.
module tb_cpu16_fde;

  logic        ck = 1'b0;
  logic        rst = 1'b0;
  logic [8:0]  pc = '0;
  logic        imem_we = 1'b0;
  logic [8:0]  imem_waddr = '0;
  logic [15:0] imem_wdata = '0;
  logic [15:0] ld_data = '0;
  logic [8:0]  next_pc;
  logic        is_jump;
  logic        is_halt;
  logic        is_load;
  logic [8:0]  load_addr;
  logic        is_write;
  logic [8:0]  write_addr;
  logic [15:0] data;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  typedef struct packed {
    logic [15:0] npc;
    logic [15:0] jmp;
    logic [15:0] halt;
    logic [15:0] ld;
    logic [15:0] la;
    logic [15:0] wr;
    logic [15:0] wa;
    logic [15:0] dat;
    logic [15:0] rwe;
    logic [15:0] rwa;
    logic [15:0] rwd;
  } exp_t;

  logic [15:0] mreg [16];
  logic        mhalt;
  logic [15:0] mem [512];
  exp_t        cur_e;

  localparam logic [15:0] PROG [0:27] = '{
    16'h1105, 16'h12FD, 16'h2312, 16'h3421, 16'hA300, 16'hA401, 16'h1104, 16'h1755,
    16'hA713, 16'h9813, 16'hA800, 16'hB1F0, 16'h117F, 16'h1909, 16'h7219, 16'h8319,
    16'hA200, 16'hA300, 16'hE1FF, 16'hA100, 16'h4419, 16'h5519, 16'h6619, 16'hA600,
    16'hA400, 16'hA500, 16'hF000, 16'hA100
  };

  cpu16_fde dut (
    .ck         (ck),
    .rst        (rst),
    .pc         (pc),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .ld_data    (ld_data),
    .next_pc    (next_pc),
    .is_jump    (is_jump),
    .is_halt    (is_halt),
    .is_load    (is_load),
    .load_addr  (load_addr),
    .is_write   (is_write),
    .write_addr (write_addr),
    .data       (data)
  );

  always #5 ck = ~ck;

  function automatic logic [15:0] wrap16(input longint x);
    return 16'(((x % 65536) + 65536) % 65536);
  endfunction

  // Reference behaviour computed with plain integer arithmetic.
  function automatic exp_t model_eval(input logic [15:0] inst, input logic [8:0] p,
                                      input logic [15:0] ldd, input logic r, input logic h,
                                      input logic [15:0] rf [16]);
    exp_t   e;
    longint op, rd, rs, rb, a, vrd, vrb, imm, d4, sd4, addr;
    e = '0;
    if (r) return e;
    op  = longint'(inst[15:12]);
    rd  = longint'(inst[11:8]);
    rs  = longint'(inst[7:4]);
    rb  = longint'(inst[3:0]);
    a   = longint'(rf[rs]);
    vrd = longint'(rf[rd]);
    vrb = longint'(rf[rb]);
    imm = longint'(inst[7:0]);
    if (imm >= 128) imm = imm - 256;
    d4  = longint'(inst[3:0]);
    sd4 = (d4 >= 8) ? d4 - 16 : d4;
    addr = ((a % 512) + d4) % 512;
    if (h || op == 15) begin
      e.halt = 16'd1;
      e.npc  = 16'(p);
      return e;
    end
    e.npc = 16'((longint'(p) + 1) % 512);
    e.rwa = 16'(rd);
    case (op)
      1:  begin e.rwe = 1; e.rwd = wrap16(imm); end
      2:  begin e.rwe = 1; e.rwd = wrap16(a + vrb); end
      3:  begin e.rwe = 1; e.rwd = wrap16(a - vrb); end
      4:  begin e.rwe = 1; e.rwd = rf[rs] & rf[rb]; end
      5:  begin e.rwe = 1; e.rwd = rf[rs] | rf[rb]; end
      6:  begin e.rwe = 1; e.rwd = rf[rs] ^ rf[rb]; end
      7:  begin e.rwe = 1; e.rwd = wrap16(a * (longint'(1) << (vrb % 16))); end
      8:  begin e.rwe = 1; e.rwd = wrap16(a / (longint'(1) << (vrb % 16))); end
      9:  begin e.rwe = 1; e.rwd = ldd; e.ld = 1; e.la = 16'(addr); end
      10: begin e.wr = 1; e.wa = 16'(addr); e.dat = rf[rd]; end
      11: begin e.jmp = 1; e.npc = 16'(inst[8:0]); end
      12: if (vrd == a) begin e.jmp = 1; e.npc = 16'((longint'(p) + sd4 + 512) % 512); end
      13: if (vrd != a) begin e.jmp = 1; e.npc = 16'((longint'(p) + sd4 + 512) % 512); end
      14: begin e.rwe = 1; e.rwd = wrap16(vrd + imm); end
      default: ;
    endcase
    return e;
  endfunction

  always_comb cur_e = model_eval(mem[pc], pc, ld_data, rst, mhalt, mreg);

  always @(posedge ck) begin
    if (imem_we) mem[imem_waddr] <= imem_wdata;
  end

  always @(posedge ck or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mreg[i] <= '0;
      mhalt <= 1'b0;
    end else begin
      if (cur_e.rwe[0]) mreg[cur_e.rwa[3:0]] <= cur_e.rwd;
      if (cur_e.halt[0]) mhalt <= 1'b1;
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge ck) begin
    if (check_en) begin
      checkOutput("m_next_pc",    16'(next_pc),    cur_e.npc);
      checkOutput("m_is_jump",    16'(is_jump),    cur_e.jmp);
      checkOutput("m_is_halt",    16'(is_halt),    cur_e.halt);
      checkOutput("m_is_load",    16'(is_load),    cur_e.ld);
      checkOutput("m_load_addr",  16'(load_addr),  cur_e.la);
      checkOutput("m_is_write",   16'(is_write),   cur_e.wr);
      checkOutput("m_write_addr", 16'(write_addr), cur_e.wa);
      checkOutput("m_data",       data,            cur_e.dat);
    end
  end

  task automatic loadWord(input logic [8:0] a, input logic [15:0] w);
    @(posedge ck);
    #1;
    imem_we    = 1'b1;
    imem_waddr = a;
    imem_wdata = w;
  endtask

  task automatic applyStimulus(input logic [8:0] p, input logic [15:0] ld, input logic r);
    @(posedge ck);
    #1;
    pc      = p;
    ld_data = ld;
    rst     = r;
    @(negedge ck);
    #1;
  endtask

  initial begin
    #1 rst = 1'b1;
    #1 check_en = 1'b1;

    for (int a = 0; a < 512; a++) loadWord(9'(a), 16'h0000);
    for (int a = 0; a < 28; a++) loadWord(9'(a), PROG[a]);
    loadWord(9'h1F0, 16'hC11E);
    loadWord(9'h1F1, 16'hD11E);
    @(posedge ck);
    #1 imem_we = 1'b0;
    @(negedge ck);
    #1;

    checkOutput("rst_next_pc",  16'(next_pc),  16'h0000);
    checkOutput("rst_is_halt",  16'(is_halt),  16'h0000);
    checkOutput("rst_is_write", 16'(is_write), 16'h0000);

    // Arithmetic and sign-extended immediates
    applyStimulus(9'd0, 16'h0, 1'b0); checkOutput("t1_npc0", 16'(next_pc), 16'h0001);
    applyStimulus(9'd1, 16'h0, 1'b0); checkOutput("t1_npc1", 16'(next_pc), 16'h0002);
    applyStimulus(9'd2, 16'h0, 1'b0); checkOutput("t1_npc2", 16'(next_pc), 16'h0003);
    applyStimulus(9'd3, 16'h0, 1'b0);
    applyStimulus(9'd4, 16'h0, 1'b0); checkOutput("t1_add", data, 16'h0002);
    applyStimulus(9'd5, 16'h0, 1'b0); checkOutput("t1_sub", data, 16'hFFF8);

    // Store and load addressing
    applyStimulus(9'd6, 16'h0, 1'b0);
    applyStimulus(9'd7, 16'h0, 1'b0);
    applyStimulus(9'd8, 16'h0, 1'b0);
    checkOutput("t2_st_we",   16'(is_write),   16'h0001);
    checkOutput("t2_st_addr", 16'(write_addr), 16'h0007);
    checkOutput("t2_st_data", data,            16'h0055);
    applyStimulus(9'd9, 16'hBEEF, 1'b0);
    checkOutput("t2_ld_en",   16'(is_load),   16'h0001);
    checkOutput("t2_ld_addr", 16'(load_addr), 16'h0007);
    applyStimulus(9'd10, 16'h0, 1'b0); checkOutput("t2_ld_val", data, 16'hBEEF);

    // Jumps and branches
    applyStimulus(9'd11, 16'h0, 1'b0);
    checkOutput("t3_jmp_npc", 16'(next_pc), 16'h01F0);
    checkOutput("t3_jmp_j",   16'(is_jump), 16'h0001);
    applyStimulus(9'h1F0, 16'h0, 1'b0);
    checkOutput("t3_beq_npc", 16'(next_pc), 16'h01EE);
    checkOutput("t3_beq_j",   16'(is_jump), 16'h0001);
    applyStimulus(9'h1F1, 16'h0, 1'b0);
    checkOutput("t3_bne_npc", 16'(next_pc), 16'h01F2);
    checkOutput("t3_bne_j",   16'(is_jump), 16'h0000);

    // PC wrap, shifts and logic ops
    applyStimulus(9'd511, 16'h0, 1'b0); checkOutput("t4_wrap", 16'(next_pc), 16'h0000);
    for (int a = 12; a < 16; a++) applyStimulus(9'(a), 16'h0, 1'b0);
    applyStimulus(9'd16, 16'h0, 1'b0); checkOutput("t4_shl", data, 16'hFE00);
    applyStimulus(9'd17, 16'h0, 1'b0); checkOutput("t4_shr", data, 16'h0000);
    applyStimulus(9'd18, 16'h0, 1'b0);
    applyStimulus(9'd19, 16'h0, 1'b0); checkOutput("t4_addi", data, 16'h007E);
    for (int a = 20; a < 23; a++) applyStimulus(9'(a), 16'h0, 1'b0);
    applyStimulus(9'd23, 16'h0, 1'b0); checkOutput("t4_xor", data, 16'h0077);
    applyStimulus(9'd24, 16'h0, 1'b0); checkOutput("t4_and", data, 16'h0008);
    applyStimulus(9'd25, 16'h0, 1'b0); checkOutput("t4_or",  data, 16'h007F);

    // Halt is immediate and sticky
    applyStimulus(9'd26, 16'h0, 1'b0);
    checkOutput("t5_halt0", 16'(is_halt), 16'h0001);
    checkOutput("t5_npc0",  16'(next_pc), 16'h001A);
    applyStimulus(9'd26, 16'h0, 1'b0);
    checkOutput("t5_halt1", 16'(is_halt), 16'h0001);
    applyStimulus(9'd27, 16'h0, 1'b0);
    checkOutput("t5_st_blk", 16'(is_write), 16'h0000);
    checkOutput("t5_npc2",   16'(next_pc),  16'h001B);

    // Asynchronous reset away from a clock edge
    #1 rst = 1'b1;
    #1;
    checkOutput("t6_halt_clr", 16'(is_halt), 16'h0000);
    checkOutput("t6_npc_rst",  16'(next_pc), 16'h0000);
    applyStimulus(9'd27, 16'h0, 1'b1);
    applyStimulus(9'd27, 16'h0, 1'b0);
    checkOutput("t6_st_we",   16'(is_write), 16'h0001);
    checkOutput("t6_r1_zero", data,          16'h0000);
    checkOutput("t6_halt_lo", 16'(is_halt),  16'h0000);
    applyStimulus(9'd8, 16'h0, 1'b0);
    checkOutput("t6_imem_ok", 16'(write_addr), 16'h0003);
    checkOutput("t6_r7_zero", data,            16'h0000);

    @(posedge ck);
    #1 check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no end of test, expected completion within 200000 time units");
    $fatal(1, "[TB] timeout");
  end

endmodule
